// File: rtl/move_sequencer.sv
// Turn-based chess move controller.
// Two clicks per move, mask-checked, committed with two board writes.
module move_sequencer #(
  parameter bit START_COLOR = 1'b0,
  parameter bit PROMOTE_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        click_valid,
  input  logic [5:0]  click_pos,
  output logic [5:0]  board_rd_addr,
  input  logic [3:0]  board_rd_data,
  output logic        board_we,
  output logic [5:0]  board_wr_addr,
  output logic [3:0]  board_wr_data,
  output logic [4:0]  ml_figure,
  output logic [5:0]  ml_position,
  input  logic [63:0] ml_moves,
  output logic        sel_valid,
  output logic [5:0]  sel_pos,
  output logic [63:0] moves_mask,
  output logic        turn,
  output logic        move_done,
  output logic        illegal,
  output logic        game_over,
  output logic        winner
);

  typedef enum logic [3:0] {
    IDLE, RD_SRC, CHK_SRC, EVAL, WAIT_DST,
    RD_DST, CHK_DST, WR_DST, WR_SRC, DONE
  } state_t;

  state_t      state, nstate;
  logic [5:0]  src, dst;
  logic [3:0]  src_code;
  logic [2:0]  cap_type;

  logic        click_ok;
  logic [2:0]  rd_type;
  logic        rd_col;
  logic        src_bad, own_dst, dst_bad;
  logic        last_row, promote;

  assign click_ok = click_valid & ~game_over;
  assign rd_type  = board_rd_data[2:0];
  assign rd_col   = board_rd_data[3];
  assign src_bad  = (rd_type == 3'd0) | (rd_col != turn);
  assign own_dst  = (rd_type != 3'd0) & (rd_col == turn);
  assign dst_bad  = ~moves_mask[dst] | (rd_type != 3'd0);
  assign last_row = src_code[3] ? (dst[5:3] == 3'd0)
                                : (dst[5:3] == 3'd7);
  assign promote  = PROMOTE_EN && (src_code[2:0] == 3'd1)
                    && last_row;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state selection
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:     if (click_ok) nstate = RD_SRC;
      RD_SRC:   nstate = CHK_SRC;
      CHK_SRC:  nstate = src_bad ? IDLE : EVAL;
      EVAL:     nstate = WAIT_DST;
      WAIT_DST: begin
        if (click_ok) begin
          if (click_pos == src) nstate = IDLE;
          else                  nstate = RD_DST;
        end
      end
      RD_DST:   nstate = CHK_DST;
      CHK_DST: begin
        if (own_dst)      nstate = EVAL;
        else if (dst_bad) nstate = WAIT_DST;
        else              nstate = WR_DST;
      end
      WR_DST:   nstate = WR_SRC;
      WR_SRC:   nstate = DONE;
      DONE:     nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end

  // Board write port, strictly one write per state
  always_comb begin
    board_we      = 1'b0;
    board_wr_addr = 6'd0;
    board_wr_data = 4'd0;
    if (state == WR_DST) begin
      board_we      = 1'b1;
      board_wr_addr = dst;
      board_wr_data = promote ? {src_code[3], 3'd5}
                              : src_code;
    end else if (state == WR_SRC) begin
      board_we      = 1'b1;
      board_wr_addr = src;
    end
  end

  // Selection, mask, turn and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      board_rd_addr <= '0;
      ml_figure     <= '0;
      ml_position   <= '0;
      sel_valid     <= 1'b0;
      sel_pos       <= '0;
      moves_mask    <= '0;
      turn          <= START_COLOR;
      move_done     <= 1'b0;
      illegal       <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
      src           <= '0;
      dst           <= '0;
      src_code      <= '0;
      cap_type      <= '0;
    end else begin
      illegal   <= 1'b0;
      move_done <= 1'b0;
      case (state)
        IDLE: begin
          if (click_ok) begin
            board_rd_addr <= click_pos;
            src           <= click_pos;
          end
        end
        CHK_SRC: begin
          if (src_bad) begin
            illegal <= 1'b1;
          end else begin
            ml_figure   <= {1'b0, board_rd_data};
            ml_position <= src;
            src_code    <= board_rd_data;
          end
        end
        EVAL: begin
          moves_mask <= ml_moves;
          sel_valid  <= 1'b1;
          sel_pos    <= src;
        end
        WAIT_DST: begin
          if (click_ok) begin
            if (click_pos == src) begin
              sel_valid  <= 1'b0;
              moves_mask <= '0;
            end else begin
              board_rd_addr <= click_pos;
              dst           <= click_pos;
            end
          end
        end
        CHK_DST: begin
          if (own_dst) begin
            src         <= dst;
            src_code    <= board_rd_data;
            ml_figure   <= {1'b0, board_rd_data};
            ml_position <= dst;
          end else if (dst_bad) begin
            illegal <= 1'b1;
          end else begin
            cap_type <= rd_type;
          end
        end
        DONE: begin
          move_done  <= 1'b1;
          sel_valid  <= 1'b0;
          moves_mask <= '0;
          if (cap_type == 3'd6) begin
            game_over <= 1'b1;
            winner    <= turn;
          end else begin
            turn <= ~turn;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Turn-based move controller for the chess game logic.
- Accepts two board clicks per move: source, then destination. Reads figure codes from the board storage and drives the combinational move-mask generator (figure code plus position in, 64-bit possible-move mask out).
- Validates the destination against the returned mask, then commits the move to the board with two sequenced writes.
- Tracks side to move, pawn promotion and game-over on king capture. Sits between the mouse/click decoder and the board RAM.

Parameters:
START_COLOR, 0, side that moves first (0 = white, 1 = black)
PROMOTE_EN, 1, 1 = a pawn reaching row 7 (white) or row 0 (black) is written back as a queen

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
click_valid  in  1  single-cycle pulse: a board square was clicked
click_pos  in  6  clicked square; [2:0] = column, [5:3] = row
board_rd_addr  out  6  board read address, registered
board_rd_data  in  4  figure code at board_rd_addr, valid one cycle after the address; [3] = colour (1 = black), [2:0] = type (0 empty, 1 pawn, 2 rook, 3 knight, 4 bishop, 5 queen, 6 king)
board_we  out  1  board write strobe, one cycle
board_wr_addr  out  6  board write address
board_wr_data  out  4  figure code to write
ml_figure  out  5  to move-mask generator: {1'b0, figure code}
ml_position  out  6  to move-mask generator: source square
ml_moves  in  64  mask from the generator, combinational from ml_figure/ml_position
sel_valid  out  1  a source square is selected and highlighted
sel_pos  out  6  selected source square
moves_mask  out  64  latched mask for display highlighting
turn  out  1  side to move (0 = white, 1 = black)
move_done  out  1  one-cycle pulse after a committed move
illegal  out  1  one-cycle pulse on a rejected click
game_over  out  1  sticky; set when a king is captured
winner  out  1  valid while game_over is 1; colour that captured the king

Behaviour:
- Reset: state IDLE.
  - turn = START_COLOR.
  - All other outputs 0: moves_mask, sel_pos, board_*, ml_* all zero.
  - Reset mid-operation aborts any move. A write already issued stays; the pending second write is dropped.
- Clicks are accepted only in IDLE and WAIT_DST. They are ignored in every other state and whenever game_over = 1.
- States:
  - IDLE: on click_valid, set board_rd_addr = click_pos, latch src = click_pos → RD_SRC.
  - RD_SRC: wait one cycle for RAM latency → CHK_SRC.
  - CHK_SRC: sample board_rd_data.
    - If type = 0 or colour ≠ turn: pulse illegal → IDLE.
    - Otherwise drive ml_figure/ml_position, latch src_code → EVAL.
  - EVAL: latch ml_moves into moves_mask, set sel_valid = 1, sel_pos = src → WAIT_DST.
    - sel_valid therefore rises 4 cycles after the accepting click.
  - WAIT_DST:
    - Click on src: deselect (sel_valid = 0, moves_mask = 0) → IDLE.
    - Any other click: set board_rd_addr = click_pos, latch dst → RD_DST.
  - RD_DST: wait one cycle → CHK_DST.
  - CHK_DST: sample the destination code.
    - Own-colour piece: reselect, i.e. src = dst, reuse the sampled code → drive ml, go to EVAL.
    - moves_mask[dst] = 0, or destination holds a piece: pulse illegal, stay selected → WAIT_DST.
    - Otherwise latch cap_code → WR_DST.
  - WR_DST: board_we = 1, addr = dst, data = src_code.
    - If PROMOTE_EN and src_code is a pawn reaching its last row, data = {colour, 3'd5}.
    - Next → WR_SRC.
  - WR_SRC: board_we = 1, addr = src, data = 0 → DONE.
  - DONE:
    - Pulse move_done, clear sel_valid and moves_mask.
    - If cap_code type = 6: set game_over, winner = turn; turn is not toggled.
    - Otherwise toggle turn.
    - → IDLE.
- Captures: the mask marks only empty squares, so a destination holding an opponent piece is illegal. The capture path in DONE is kept for future mask extensions.
- Exactly one board write per cycle; board_we is never high outside WR_DST/WR_SRC.
- A click arriving in the same cycle as a write is ignored, not queued.
- game_over is cleared only by rst.
- Mask indexing: bit row*8 + col.

Test Plan:
- Reset, white pawn (code 4'h1) at pos 8, generator returns bits 16 and 24 → click 8, click 24 → board_we at addr 24 with data 1, then at addr 8 with data 0; move_done pulses once; turn becomes 1.
- turn = 0, click a black piece (code 4'h9) → illegal pulses 3 cycles after the click; sel_valid stays 0.
- Selected source, click a square whose mask bit is 0 → illegal pulses; sel_valid stays 1; no board_we.
- Selected source at pos 3, click the same square 3 → sel_valid = 0, moves_mask = 0, state IDLE, turn unchanged.
- Selected white rook, click a white knight at pos 6 → sel_pos = 6, moves_mask equals the generator output for knight at 6, no writes.
- White pawn at 48 moves to 56 with PROMOTE_EN = 1 → write data 4'h5 at 56. Separately: rst asserted during WR_DST → no WR_SRC write occurs and turn = START_COLOR.
